regfile: RTL

Architectural register file with rename tags for the out-of-order RISC-V core. It sits directly downstream of the reorder buffer: it consumes commit records (destination, value, ROB tag) and writes architectural state. It also serves dispatch. On each instruction it returns operand values or the pending ROB tag, and it records the new producer tag for the destination register.

---
 rtl/regfile_pkg.sv | 24 ++
 rtl/regfile_if.sv | 34 +++
 rtl/regfile_read_port.sv | 31 +++
 rtl/regfile.sv | 75 +++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared widths and types for the architectural register file.
// The ROB tag is one bit wider than a slot index so that ROB_SIZE itself can act as the "no producer" value.
`ifndef REGFILE_DEFINES
`define REGFILE_DEFINES
`define DATA_WIDTH    32
`define REG_TAG_WIDTH 5
`define ROB_SIZE      8
`define ROB_TAG_WIDTH 4
`define TRUE          1'b1
`define FALSE         1'b0
`endif

package regfile_pkg;
  localparam int DATA_WIDTH    = `DATA_WIDTH;
  localparam int REG_TAG_WIDTH = `REG_TAG_WIDTH;
  localparam int ROB_TAG_WIDTH = `ROB_TAG_WIDTH;
  localparam int ROB_SIZE      = `ROB_SIZE;

  typedef logic [DATA_WIDTH-1:0]    data_t;
  typedef logic [REG_TAG_WIDTH-1:0] reg_idx_t;
  typedef logic [ROB_TAG_WIDTH-1:0] rob_tag_t;

  localparam rob_tag_t ROB_NONE_TAG = rob_tag_t'(ROB_SIZE);
endpackage

// File: rtl/regfile_if.sv
// Dispatch, commit and operand signals between the core and the register file.
// The master side is dispatch/ROB; the slave side is the register file.
interface regfile_if;
  import regfile_pkg::*;

  logic     rdy;
  logic     in_clear;
  reg_idx_t in_decode_rs1;
  reg_idx_t in_decode_rs2;
  logic     in_decode_rename;
  reg_idx_t in_decode_rd;
  rob_tag_t in_decode_reorder;
  reg_idx_t in_rob_index;
  data_t    in_rob_value;
  rob_tag_t in_rob_reorder;
  data_t    out_rs1_value;
  rob_tag_t out_rs1_reorder;
  data_t    out_rs2_value;
  rob_tag_t out_rs2_reorder;

  modport master (
    output rdy, in_clear,
    output in_decode_rs1, in_decode_rs2, in_decode_rename, in_decode_rd, in_decode_reorder,
    output in_rob_index, in_rob_value, in_rob_reorder,
    input  out_rs1_value, out_rs1_reorder, out_rs2_value, out_rs2_reorder
  );

  modport slave (
    input  rdy, in_clear,
    input  in_decode_rs1, in_decode_rs2, in_decode_rename, in_decode_rd, in_decode_reorder,
    input  in_rob_index, in_rob_value, in_rob_reorder,
    output out_rs1_value, out_rs1_reorder, out_rs2_value, out_rs2_reorder
  );
endinterface

// File: rtl/regfile_read_port.sv
// One combinational operand read: x0 forcing, same-cycle commit bypass, else stored state.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter rob_tag_t ROB_NONE = ROB_NONE_TAG
) (
  input  reg_idx_t rs_idx,
  input  data_t    reg_value,
  input  rob_tag_t reg_reorder,
  input  logic     commit_en,
  input  reg_idx_t rob_index,
  input  data_t    rob_value,
  input  rob_tag_t rob_reorder,
  output data_t    rs_value,
  output rob_tag_t rs_reorder
);

  always_comb begin
    rs_value   = reg_value;
    rs_reorder = reg_reorder;
    if (rs_idx == '0) begin
      rs_value   = '0;
      rs_reorder = ROB_NONE;
    end else if (commit_en && (rob_index == rs_idx) && (rob_reorder == reg_reorder)) begin
      // Only the producer the register is waiting on may bypass; an older commit is stale.
      rs_value   = rob_value;
      rs_reorder = ROB_NONE;
    end
  end

endmodule

// File: rtl/regfile.sv
// Architectural register file with per-register rename tags.
// Commits write values, dispatch records producer tags, and a flush drops every pending tag.
module regfile
  import regfile_pkg::*;
#(
  parameter int       REG_COUNT = 32,
  parameter rob_tag_t ROB_NONE  = ROB_NONE_TAG
) (
  input logic      clk,
  input logic      rst,
  regfile_if.slave bus
);

  data_t    value_q   [REG_COUNT];
  rob_tag_t reorder_q [REG_COUNT];

  logic commit_valid;
  logic commit_en;
  logic rename_en;

  assign commit_valid = (bus.in_rob_reorder != ROB_NONE);
  assign commit_en    = commit_valid && (bus.in_rob_index != '0);
  assign rename_en    = bus.in_decode_rename && (bus.in_decode_rd != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        value_q[i]   <= '0;
        reorder_q[i] <= ROB_NONE;
      end
    end else if (bus.rdy) begin
      if (commit_en) begin
        value_q[bus.in_rob_index] <= bus.in_rob_value;
      end
      if (bus.in_clear) begin
        for (int i = 0; i < REG_COUNT; i++) begin
          reorder_q[i] <= ROB_NONE;
        end
      end else begin
        if (commit_en && (reorder_q[bus.in_rob_index] == bus.in_rob_reorder)) begin
          reorder_q[bus.in_rob_index] <= ROB_NONE;
        end
        // Issued last so a same-register rename overrides the commit's tag release.
        if (rename_en) begin
          reorder_q[bus.in_decode_rd] <= bus.in_decode_reorder;
        end
      end
    end
  end

  regfile_read_port #(.ROB_NONE(ROB_NONE)) u_read_rs1 (
    .rs_idx      (bus.in_decode_rs1),
    .reg_value   (value_q[bus.in_decode_rs1]),
    .reg_reorder (reorder_q[bus.in_decode_rs1]),
    .commit_en   (commit_valid),
    .rob_index   (bus.in_rob_index),
    .rob_value   (bus.in_rob_value),
    .rob_reorder (bus.in_rob_reorder),
    .rs_value    (bus.out_rs1_value),
    .rs_reorder  (bus.out_rs1_reorder)
  );

  regfile_read_port #(.ROB_NONE(ROB_NONE)) u_read_rs2 (
    .rs_idx      (bus.in_decode_rs2),
    .reg_value   (value_q[bus.in_decode_rs2]),
    .reg_reorder (reorder_q[bus.in_decode_rs2]),
    .commit_en   (commit_valid),
    .rob_index   (bus.in_rob_index),
    .rob_value   (bus.in_rob_value),
    .rob_reorder (bus.in_rob_reorder),
    .rs_value    (bus.out_rs2_value),
    .rs_reorder  (bus.out_rs2_reorder)
  );

endmodule
